// File: rtl/fft_frame_reader.sv
// fft_frame_reader: streams a stored FFT frame out on valid/ready; FFT_FRAME_READER_BITREV_EN selects bit-reversed read addresses
module fft_frame_reader #(
   parameter int ADDR_W    = 12,
   parameter int DATA_W    = 32,
   parameter int MAX_LOG2N = 12
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [3:0]        log2n,
   output logic              busy,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [DATA_W-1:0] rd_data,
   output logic [DATA_W-1:0] m_data,
   output logic              m_valid,
   input  logic              m_ready,
   output logic              m_last,
   output logic              done
);
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] READ  = 2'd1;
   localparam logic [1:0] DRAIN = 2'd2;
   localparam logic [3:0] MAXL  = 4'(MAX_LOG2N);
   localparam logic [ADDR_W:0] ONE = {{ADDR_W{1'b0}}, 1'b1};

   logic [1:0]        state, cnt;
   logic [3:0]        lg, lg_in;
   logic [ADDR_W:0]   idx, last_idx;
   logic [ADDR_W-1:0] ocnt;
   logic              inflight, pop;
   logic [DATA_W-1:0] b0, b1;

   assign lg_in    = log2n == 4'd0 ? 4'd1 : log2n > MAXL ? MAXL : log2n;
   assign last_idx = (ONE << lg) - ONE;
   assign m_valid  = cnt != 2'd0;
   assign pop      = m_valid & m_ready;
   assign m_data   = b0;
   assign m_last   = m_valid && ocnt == last_idx[ADDR_W-1:0];
   // buffered + in-flight samples never exceed the 2-entry buffer
   assign rd_en    = state == READ && ({1'b0, cnt} + {2'b0, inflight} - {2'b0, pop}) < 3'd2;
   assign done     = state == DRAIN && cnt == 2'd0 && !inflight;
   assign busy     = state != IDLE && !done;

`ifdef FFT_FRAME_READER_BITREV_EN
   localparam logic [5:0] AW = 6'(ADDR_W);
   logic [ADDR_W-1:0] rev;
   always_comb begin
      rev = '0;
      for (int i = 0; i < ADDR_W; i++) rev[i] = idx[ADDR_W-1-i];
   end
   // idx < 2^L, so reversing all bits then shifting down leaves the low L bits reversed
   assign rd_addr = rev >> (AW - {2'b0, lg});
`else
   assign rd_addr = idx[ADDR_W-1:0];
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= '0;
         lg       <= '0;
         idx      <= '0;
         ocnt     <= '0;
         inflight <= 1'b0;
         b0       <= '0;
         b1       <= '0;
      end else begin
         inflight <= rd_en;
         cnt      <= cnt + {1'b0, inflight} - {1'b0, pop};
         if (inflight && (pop ? cnt == 2'd2 : cnt == 2'd1)) b1 <= rd_data;
         if (pop) b0 <= (inflight && cnt == 2'd1) ? rd_data : b1;
         else if (inflight && cnt == 2'd0) b0 <= rd_data;
         if (pop) ocnt <= ocnt + 1'b1;
         if (rd_en) idx <= idx + 1'b1;
         if (state == IDLE && start) begin
            state <= READ;
            lg    <= lg_in;
            idx   <= '0;
            ocnt  <= '0;
         end else if (state == READ && rd_en && idx == last_idx) state <= DRAIN;
         else if (done) state <= IDLE;
      end
   end
endmodule

// File: tb/tb_fft_frame_reader.sv
// tb_fft_frame_reader: scoreboard bench for fft_frame_reader with a 1-cycle-latency buffer model (buffer[a] = a + 0x100)
module tb_fft_frame_reader;
   logic        clk = 1'b0, rst = 1'b1, start = 1'b0, m_ready = 1'b0;
   logic [3:0]  log2n = 4'd0;
   logic        busy, rd_en, m_valid, m_last, done;
   logic [11:0] rd_addr;
   logic [31:0] rd_data = 32'h0, m_data;

   fft_frame_reader dut (
      .clk(clk), .rst(rst), .start(start), .log2n(log2n), .busy(busy),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .m_data(m_data),
      .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last), .done(done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) rd_data <= rd_en ? 32'h100 + 32'(rd_addr) : 32'hDEADBEEF;

   int rmode = 0;
   initial forever begin
      @(posedge clk);
      #1;
      m_ready = rmode == 0 ? 1'b1 : rmode == 1 ? 1'($urandom_range(0, 1)) : 1'b0;
   end

   int checks = 0, errors = 0;
   int outs = 0, beats = 0, n_rd = 0, done_cnt = 0, d0 = 0, t0 = 0;
   int first_rd = 0, first_v = 0, last_cyc = 0, done_cyc = 0;
   bit seen_v = 0, prev_stall = 0, held_last = 0;
   logic [31:0] held_data = 32'h0;
   int qa[$];
   logic [31:0] qd[$];
   bit ql[$];

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   function automatic int exp_addr_f(input int i, input int l);
`ifdef FFT_FRAME_READER_BITREV_EN
      int r = 0;
      for (int b = 0; b < l; b++) if (i[b]) r |= 1 << (l - 1 - b);
      return r;
`else
      return i;
`endif
   endfunction

   always @(negedge clk) begin
      if (rst) begin
         chk("reset_outputs", {busy, m_valid, done, rd_en, m_last}, 0);
         outs = 0;
         prev_stall = 0;
      end else begin
         int p;
         p = int'(m_valid && m_ready);
         if (prev_stall) begin
            chk("stall_valid", m_valid, 1);
            chk("stall_data", m_data, held_data);
            chk("stall_last", m_last, held_last);
         end
         if (rd_en) begin
            if (n_rd == 0) first_rd = cyc;
            n_rd++;
            chk("issue_limit", longint'((outs - p) < 2), 1);
            if (qa.size() == 0) chk("unexpected_rd", 1, 0);
            else chk("rd_addr", rd_addr, qa.pop_front());
         end
         if (m_valid && !seen_v) begin
            seen_v = 1;
            first_v = cyc;
         end
         if (p == 1) begin
            beats++;
            if (m_last) last_cyc = cyc;
            if (qd.size() == 0) chk("unexpected_beat", 1, 0);
            else begin
               chk("m_data", m_data, qd.pop_front());
               chk("m_last", m_last, ql.pop_front());
            end
         end
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
            chk("done_after_last", cyc, last_cyc + 1);
         end
         outs += int'(rd_en) - p;
         prev_stall = m_valid && !m_ready;
         held_data = m_data;
         held_last = m_last;
      end
   end

   task automatic start_frame(input logic [3:0] lv, input int l);
      int n = 1 << l;
      for (int i = 0; i < n; i++) begin
         int a = exp_addr_f(i, l);
         qa.push_back(a);
         qd.push_back(32'h100 + 32'(a));
         ql.push_back(i == n - 1);
      end
      beats = 0;
      n_rd = 0;
      seen_v = 0;
      d0 = done_cnt;
      @(posedge clk);
      #1;
      log2n = lv;
      start = 1'b1;
      t0 = cyc;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input int n, input int budget);
      for (int i = 0; i < budget && done_cnt == d0; i++) @(posedge clk);
      chk("done_seen", done_cnt - d0, 1);
      repeat (3) @(posedge clk);
      #1;
      chk("done_once", done_cnt - d0, 1);
      chk("beat_count", beats, n);
      chk("queue_empty", qd.size(), 0);
      chk("busy_idle", busy, 0);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      chk("idle_quiet", {m_valid, rd_en, busy, done}, 0);

      start_frame(4'd3, 3);
      wait_done(8, 100);
      chk("lat_first_rd", first_rd - t0, 1);
      chk("lat_first_valid", first_v - t0, 3);
      chk("lat_last", last_cyc - t0, 10);
      chk("lat_done", done_cyc - t0, 11);

      rmode = 1;
      start_frame(4'd4, 4);
      for (int i = 0; i < 200 && beats < 5; i++) @(posedge clk);
      rmode = 2;
      repeat (6) @(posedge clk);
      rmode = 1;
      wait_done(16, 400);
      rmode = 0;

      start_frame(4'd0, 1);
      wait_done(2, 50);

      start_frame(4'd3, 3);
      repeat (3) @(posedge clk);
      #1;
      log2n = 4'd5;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      wait_done(8, 100);

      start_frame(4'd15, 12);
      wait_done(4096, 5000);

      start_frame(4'd5, 5);
      for (int i = 0; i < 200 && beats < 5; i++) @(posedge clk);
      #1 rst = 1'b1;
      qa.delete();
      qd.delete();
      ql.delete();
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      start_frame(4'd5, 5);
      wait_done(32, 200);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
